// File: rtl/dm_pkg.sv
// Shared encodings, FSM state type and load helpers for the dm_ctrl data memory.
package dm_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [2:0] nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: nbytes = 3'd1;
         SZ_HALF: nbytes = 3'd2;
         SZ_WORD: nbytes = 3'd4;
         default: nbytes = 3'd0;
      endcase
   endfunction

   // data arrives right-aligned; widen it to 32 bits with sign or zero fill
   function automatic logic [31:0] ext_load(input logic [31:0] data,
                                            input logic [1:0]  size,
                                            input logic        unsigned_ld);
      case (size)
         SZ_BYTE: ext_load = unsigned_ld ? {24'b0, data[7:0]}
                                         : {{24{data[7]}}, data[7:0]};
         SZ_HALF: ext_load = unsigned_ld ? {16'b0, data[15:0]}
                                         : {{16{data[15]}}, data[15:0]};
         default: ext_load = data;
      endcase
   endfunction

endpackage

// File: rtl/dm_if.sv
// Request/ready handshake bundle between a load/store unit and dm_ctrl.
interface dm_if #(
   parameter int ADDR_W = 32
) ();

   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              unsigned_ld;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              fault;
   logic              busy;
   logic [31:0]       rdata;

   modport master (
      output req, we, size, unsigned_ld, addr, wdata,
      input  ready, fault, busy, rdata
   );

   modport slave (
      input  req, we, size, unsigned_ld, addr, wdata,
      output ready, fault, busy, rdata
   );

endinterface

// File: rtl/dm_array.sv
// Byte-wide storage with a 4-lane byte-enable write port and a 4-lane combinational read.
module dm_array #(
   parameter  int DEPTH_BYTES = 32,
   localparam int IDX_W       = $clog2(DEPTH_BYTES)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   input  logic [3:0]       wr_en,
   input  logic [3:0][7:0]  wr_bytes,
   output logic [3:0][7:0]  rd_bytes
);

   logic [7:0]            mem [DEPTH_BYTES];
   logic [3:0][IDX_W-1:0] lane_idx;

   // lane i addresses mem[addr+i]; the index wraps, so lanes past the end stay in range
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_idx[i] = addr + IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            mem[lane_idx[i]] <= wr_bytes[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rd_bytes[i] = mem[lane_idx[i]];
      end
   end

endmodule

// File: rtl/dm_ctrl.sv
// Big-endian byte-addressed data memory controller with wait states, size checks and
// sign/zero-extended loads; lane 0 of the array always carries the byte at addr.
module dm_ctrl
   import dm_pkg::*;
#(
   parameter int DEPTH_BYTES = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input logic clk,
   input logic rst,
   dm_if.slave bus
);

   localparam int              IDX_W     = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(DEPTH_BYTES);
   localparam logic [2:0]      WAIT_INIT = 3'(WAIT_STATES);
   localparam bit              NO_WAIT   = (WAIT_STATES == 0);

   state_e           state;
   logic [2:0]       cnt;
   logic             ready_q;
   logic             fault_q;
   logic             busy_q;
   logic [31:0]      rdata_q;

   logic             lat_we;
   logic             lat_uns;
   logic [1:0]       lat_size;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_wdata;

   logic [ADDR_W:0]  end_addr;
   logic             req_fault;
   logic             in_idle;
   logic             do_access;

   logic             acc_we;
   logic             acc_uns;
   logic [1:0]       acc_size;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_wdata;

   logic [3:0]       lane_mask;
   logic [3:0]       wr_en;
   logic [3:0][7:0]  wr_bytes;
   logic [3:0][7:0]  rd_bytes;
   logic [31:0]      load_raw;

   // one bit of headroom keeps addr+nbytes from wrapping near the top of the address space
   always_comb begin
      end_addr  = {1'b0, bus.addr} + (ADDR_W+1)'(nbytes(bus.size));
      req_fault = 1'b0;
      if (bus.size == SZ_ILLEGAL) begin
         req_fault = 1'b1;
      end
      if (bus.size == SZ_HALF && bus.addr[0]) begin
         req_fault = 1'b1;
      end
      if (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00) begin
         req_fault = 1'b1;
      end
      if (end_addr > LIMIT) begin
         req_fault = 1'b1;
      end
   end

   assign in_idle = (state == ST_IDLE);

   // zero-wait accesses execute on the accepting edge, so they use the live request fields
   always_comb begin
      acc_we    = in_idle ? bus.we                 : lat_we;
      acc_uns   = in_idle ? bus.unsigned_ld        : lat_uns;
      acc_size  = in_idle ? bus.size               : lat_size;
      acc_idx   = in_idle ? bus.addr[IDX_W-1:0]    : lat_idx;
      acc_wdata = in_idle ? bus.wdata              : lat_wdata;
   end

   assign do_access = (in_idle && bus.req && !req_fault && NO_WAIT)
                    || (state == ST_WAIT && cnt == 3'd1);

   always_comb begin
      lane_mask = 4'b0000;
      wr_bytes  = '0;
      load_raw  = 32'b0;
      case (acc_size)
         SZ_BYTE: begin
            lane_mask   = 4'b0001;
            wr_bytes[0] = acc_wdata[7:0];
            load_raw    = {24'b0, rd_bytes[0]};
         end
         SZ_HALF: begin
            lane_mask   = 4'b0011;
            wr_bytes[0] = acc_wdata[15:8];
            wr_bytes[1] = acc_wdata[7:0];
            load_raw    = {16'b0, rd_bytes[0], rd_bytes[1]};
         end
         SZ_WORD: begin
            lane_mask   = 4'b1111;
            wr_bytes[0] = acc_wdata[31:24];
            wr_bytes[1] = acc_wdata[23:16];
            wr_bytes[2] = acc_wdata[15:8];
            wr_bytes[3] = acc_wdata[7:0];
            load_raw    = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
         end
         default: begin
            lane_mask = 4'b0000;
         end
      endcase
   end

   // reset suppresses a store whose access edge coincides with it
   assign wr_en = (do_access && acc_we && !rst) ? lane_mask : 4'b0000;

   dm_array #(
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_array (
      .clk      (clk),
      .addr     (acc_idx),
      .wr_en    (wr_en),
      .wr_bytes (wr_bytes),
      .rd_bytes (rd_bytes)
   );

   always_ff @(posedge clk) begin
      if (in_idle && bus.req) begin
         lat_we    <= bus.we;
         lat_uns   <= bus.unsigned_ld;
         lat_size  <= bus.size;
         lat_idx   <= bus.addr[IDX_W-1:0];
         lat_wdata <= bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= 3'd0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 32'b0;
      end else begin
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         if (do_access && !acc_we) begin
            rdata_q <= ext_load(load_raw, acc_size, acc_uns);
         end
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  busy_q <= 1'b1;
                  if (req_fault) begin
                     state   <= ST_DONE;
                     ready_q <= 1'b1;
                     fault_q <= 1'b1;
                  end else if (NO_WAIT) begin
                     state   <= ST_DONE;
                     ready_q <= 1'b1;
                  end else begin
                     cnt   <= WAIT_INIT;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state   <= ST_DONE;
                  ready_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.fault = fault_q;
   assign bus.busy  = busy_q;
   assign bus.rdata = rdata_q;

endmodule
